// File: rtl/chop_gen_pkg.sv
// Shared types and helpers for the multi-channel chopper generator.
package chop_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned MIN_OUT_DELAY = 2;

    // A zero period length is run as a one-cycle period.
    function automatic logic [63:0] clamp_max(input logic [63:0] max_count);
        return (max_count == '0) ? 64'd1 : max_count;
    endfunction

endpackage

// File: rtl/chop_gen_mc_dly_line.sv
// Fixed-depth shift register used to align outputs with downstream pipeline latency.
module chop_dly_line
    import chop_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/chop_gen_mc.sv
// Multi-channel chopper generator: shared period counter, shadowed period settings,
// optional burst length, and latency-compensated chop/hold outputs.
module chop_gen_mc
    import chop_gen_pkg::*;
#(
    parameter int unsigned N_CH         = 16,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned HOLD_SAMPLES = 3,
    parameter int unsigned OUT_DELAY    = 3,
    parameter int unsigned BURST_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               chop_en,
    input  logic               burst_mode,
    input  logic [BURST_W-1:0] n_periods,
    input  logic [N_CH-1:0]    chop_default,
    input  logic [N_CH-1:0]    ch_mask,
    input  logic [CNT_W-1:0]   change_count,
    input  logic [CNT_W-1:0]   max_count,
    output logic [N_CH-1:0]    chop_o,
    output logic [N_CH-1:0]    chop_dly_o,
    output logic               data_hold_o,
    output logic               period_stb_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int unsigned DLY    = (OUT_DELAY < MIN_OUT_DELAY) ? MIN_OUT_DELAY : OUT_DELAY;
    localparam int unsigned HOLD_N = (HOLD_SAMPLES < 1) ? 1 : HOLD_SAMPLES;
    localparam int unsigned HOLD_W = $clog2(HOLD_N + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   chg_s, chg_d;
    logic [CNT_W-1:0]   max_s, max_d;
    logic [N_CH-1:0]    mask_s, mask_d;
    logic               burst_s, burst_d;
    logic [BURST_W-1:0] nper_s, nper_d;
    logic [BURST_W-1:0] pcnt_q, pcnt_d;
    logic               phase_q, phase_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [N_CH-1:0]    chop_q, chop_d;

    logic [CNT_W-1:0]   max_in;
    logic [CNT_W-1:0]   cnt_inc;
    logic [BURST_W:0]   pcnt_inc;
    logic               period_end;
    logic               burst_last;
    logic               start;
    logic               run_next;
    logic               phase_edge;
    logic               hold;

    assign max_in     = CNT_W'(clamp_max(64'(max_count)));
    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign pcnt_inc   = {1'b0, pcnt_q} + (BURST_W + 1)'(1);
    assign period_end = (cnt_q == max_s - CNT_W'(1));
    // A zero burst length still runs the one period already in progress.
    assign burst_last = burst_s && ((nper_s == '0) || (pcnt_inc == {1'b0, nper_s}));

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        chg_d   = chg_s;
        max_d   = max_s;
        mask_d  = mask_s;
        burst_d = burst_s;
        nper_d  = nper_s;
        pcnt_d  = pcnt_q;
        phase_d = 1'b0;
        start   = 1'b0;
        unique case (state_q)
            IDLE: begin
                pcnt_d = '0;
                if (chop_en) begin
                    state_d = RUN;
                    start   = 1'b1;
                    chg_d   = change_count;
                    max_d   = max_in;
                    mask_d  = ch_mask;
                    burst_d = burst_mode;
                    nper_d  = n_periods;
                end
            end
            RUN: begin
                if (!chop_en) begin
                    state_d = IDLE;
                    pcnt_d  = '0;
                end else if (period_end) begin
                    pcnt_d = pcnt_inc[BURST_W-1:0];
                    chg_d  = change_count;
                    max_d  = max_in;
                    mask_d = ch_mask;
                    if (burst_last) begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d   = cnt_inc;
                    phase_d = (chg_s != '0) && (cnt_inc >= chg_s);
                end
            end
            DONE: begin
                if (!chop_en) begin
                    state_d = IDLE;
                    pcnt_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decision so chop_o lines up with cnt.
    assign run_next   = (state_d == RUN);
    assign phase_edge = run_next && (start || (phase_d != phase_q));

    always_comb begin
        chop_d = chop_default;
        if (run_next) begin
            chop_d = chop_default ^ (mask_d & {N_CH{phase_d}});
        end
    end

    always_comb begin
        hold_cnt_d = '0;
        if (phase_edge) begin
            hold_cnt_d = HOLD_W'(HOLD_N);
        end else if (run_next && (hold_cnt_q != '0)) begin
            hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            chg_s      <= '0;
            max_s      <= CNT_W'(1);
            mask_s     <= '0;
            burst_s    <= 1'b0;
            nper_s     <= '0;
            pcnt_q     <= '0;
            phase_q    <= 1'b0;
            hold_cnt_q <= '0;
            chop_q     <= chop_default;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            chg_s      <= chg_d;
            max_s      <= max_d;
            mask_s     <= mask_d;
            burst_s    <= burst_d;
            nper_s     <= nper_d;
            pcnt_q     <= pcnt_d;
            phase_q    <= phase_d;
            hold_cnt_q <= hold_cnt_d;
            chop_q     <= chop_d;
        end
    end

    assign hold = (hold_cnt_q != '0);

    chop_dly_line #(
        .WIDTH (N_CH),
        .DEPTH (DLY)
    ) u_chop_dly (
        .clk (clk),
        .rst (rst),
        .d   (chop_q),
        .q   (chop_dly_o)
    );

    chop_dly_line #(
        .WIDTH (1),
        .DEPTH (DLY - 1)
    ) u_hold_dly (
        .clk (clk),
        .rst (rst),
        .d   (hold),
        .q   (data_hold_o)
    );

    assign chop_o       = chop_q;
    assign period_stb_o = (state_q == RUN) && period_end;
    assign busy_o       = (state_q == RUN);
    assign done_o       = (state_q == DONE);

endmodule

// File: tb/tb_chop_gen_mc.sv
// Directed and randomized checks of chop_gen_mc against a cycle-level behavioural model.
module tb_chop_gen_mc;

    localparam int N    = 2;
    localparam int CW   = 32;
    localparam int BW   = 16;
    localparam int HOLD = 3;
    localparam int DLY  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          chop_en;
    logic          burst_mode;
    logic [BW-1:0] n_periods;
    logic [N-1:0]  chop_default;
    logic [N-1:0]  ch_mask;
    logic [CW-1:0] change_count;
    logic [CW-1:0] max_count;
    logic [N-1:0]  chop_o;
    logic [N-1:0]  chop_dly_o;
    logic          data_hold_o;
    logic          period_stb_o;
    logic          busy_o;
    logic          done_o;

    chop_gen_mc #(
        .N_CH         (N),
        .CNT_W        (CW),
        .HOLD_SAMPLES (HOLD),
        .OUT_DELAY    (DLY),
        .BURST_W      (BW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .chop_en      (chop_en),
        .burst_mode   (burst_mode),
        .n_periods    (n_periods),
        .chop_default (chop_default),
        .ch_mask      (ch_mask),
        .change_count (change_count),
        .max_count    (max_count),
        .chop_o       (chop_o),
        .chop_dly_o   (chop_dly_o),
        .data_hold_o  (data_hold_o),
        .period_stb_o (period_stb_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: position within the period, settings in force, and output history.
    bit          m_run, m_done, m_phase, m_burst;
    int unsigned m_pos, m_chg, m_max, m_n, m_periods;
    logic [N-1:0] m_mask, exp_chop;
    logic [N-1:0] chop_hist[$];
    bit           edge_hist[$];
    bit           hold_hist[$];

    function automatic void model_reset();
        m_run = 1'b0; m_done = 1'b0; m_phase = 1'b0;
        exp_chop = chop_default;
        chop_hist.delete(); edge_hist.delete(); hold_hist.delete();
        chop_hist.push_back(chop_default);
        for (int i = 0; i < DLY; i++) chop_hist.push_back('0);
        for (int i = 0; i < HOLD; i++) edge_hist.push_back(1'b0);
        for (int i = 0; i < DLY; i++) hold_hist.push_back(1'b0);
    endfunction

    function automatic void model_step();
        bit prev_phase = m_phase;
        bit started    = 1'b0;
        bit edg, hold_now;
        if (!chop_en) begin
            m_run = 1'b0; m_done = 1'b0;
        end else if (!m_run && !m_done) begin
            m_run = 1'b1; started = 1'b1; m_pos = 0; m_periods = 0;
            m_chg = change_count; m_max = (max_count == 0) ? 1 : max_count;
            m_mask = ch_mask; m_burst = burst_mode; m_n = n_periods;
        end else if (m_run) begin
            if (m_pos == m_max - 1) begin
                m_periods++;
                m_chg = change_count; m_max = (max_count == 0) ? 1 : max_count;
                m_mask = ch_mask; m_pos = 0;
                if (m_burst && m_periods >= ((m_n == 0) ? 1 : m_n)) begin
                    m_run = 1'b0; m_done = 1'b1;
                end
            end else begin
                m_pos++;
            end
        end
        m_phase  = m_run && (m_chg != 0) && (m_pos >= m_chg);
        exp_chop = m_run ? (chop_default ^ (m_mask & {N{m_phase}})) : chop_default;
        edg = m_run && (started || (m_phase != prev_phase));
        chop_hist.push_front(exp_chop); void'(chop_hist.pop_back());
        edge_hist.push_front(edg);      void'(edge_hist.pop_back());
        hold_now = 1'b0;
        foreach (edge_hist[i]) hold_now |= edge_hist[i];
        hold_now &= m_run;
        hold_hist.push_front(hold_now); void'(hold_hist.pop_back());
    endfunction

    task automatic check_all();
        bit e_stb = m_run && (m_pos == m_max - 1);
        checks++;
        assert (chop_o === exp_chop) else begin
            failures++; $error("FAIL chop_o got=%b exp=%b t=%0t", chop_o, exp_chop, $time);
        end
        checks++;
        assert (chop_dly_o === chop_hist[DLY]) else begin
            failures++; $error("FAIL chop_dly_o got=%b exp=%b t=%0t", chop_dly_o, chop_hist[DLY], $time);
        end
        checks++;
        assert (data_hold_o === hold_hist[DLY-1]) else begin
            failures++; $error("FAIL data_hold_o got=%b exp=%b t=%0t", data_hold_o, hold_hist[DLY-1], $time);
        end
        checks++;
        assert (period_stb_o === e_stb) else begin
            failures++; $error("FAIL period_stb_o got=%b exp=%b t=%0t", period_stb_o, e_stb, $time);
        end
        checks++;
        assert (busy_o === m_run) else begin
            failures++; $error("FAIL busy_o got=%b exp=%b t=%0t", busy_o, m_run, $time);
        end
        checks++;
        assert (done_o === m_done) else begin
            failures++; $error("FAIL done_o got=%b exp=%b t=%0t", done_o, m_done, $time);
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
            check_all();
        end
    endtask

    task automatic setup(input int unsigned chg, input int unsigned mx, input logic [N-1:0] dflt,
                         input logic [N-1:0] msk, input bit bm, input int unsigned np);
        change_count = chg; max_count = mx; chop_default = dflt; ch_mask = msk;
        burst_mode = bm; n_periods = BW'(np);
    endtask

    initial begin
        rst = 1'b1; chop_en = 1'b0;
        setup(4, 10, 2'b01, 2'b11, 1'b0, 0);
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(3);

        // Continuous run, then a mid-period change of change_count.
        chop_en = 1'b1;
        cycle(35);
        change_count = 6;
        cycle(25);
        chop_en = 1'b0;
        cycle(3);

        // Overlapping hold runs.
        setup(1, 3, 2'b01, 2'b11, 1'b0, 0);
        chop_en = 1'b1;
        cycle(15);
        chop_en = 1'b0;
        cycle(2);

        // Burst of three periods, then a restart.
        setup(4, 8, 2'b01, 2'b11, 1'b1, 3);
        chop_en = 1'b1;
        cycle(30);
        chop_en = 1'b0;
        cycle(2);
        chop_en = 1'b1;
        cycle(30);
        chop_en = 1'b0;
        cycle(2);

        // Degenerate settings.
        setup(4, 0, 2'b10, 2'b11, 1'b0, 0);
        chop_en = 1'b1;
        cycle(6);
        chop_en = 1'b0;
        cycle(2);
        setup(12, 10, 2'b01, 2'b11, 1'b0, 0);
        chop_en = 1'b1;
        cycle(25);
        chop_en = 1'b0;
        cycle(2);
        setup(3, 7, 2'b00, 2'b10, 1'b0, 0);
        chop_en = 1'b1;
        cycle(20);
        chop_en = 1'b0;
        cycle(2);
        setup(2, 5, 2'b11, 2'b11, 1'b1, 0);
        chop_en = 1'b1;
        cycle(10);
        chop_en = 1'b0;
        cycle(2);

        // Randomized traffic with settings changing underneath the run.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) chop_en = ~chop_en;
            if ($urandom_range(0, 19) == 0) change_count = $urandom_range(0, 14);
            if ($urandom_range(0, 19) == 0) max_count = $urandom_range(0, 12);
            if ($urandom_range(0, 29) == 0) ch_mask = N'($urandom);
            if ($urandom_range(0, 29) == 0) chop_default = N'($urandom);
            if ($urandom_range(0, 24) == 0) begin
                burst_mode = 1'($urandom_range(0, 1));
                n_periods  = BW'($urandom_range(0, 4));
            end
            cycle(1);
        end
        chop_en = 1'b0;
        cycle(2);

        // Asynchronous reset in the middle of a period.
        setup(4, 10, 2'b01, 2'b11, 1'b0, 0);
        chop_en = 1'b1;
        cycle(6);
        #1;
        rst = 1'b1;
        chop_en = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(5);
        chop_en = 1'b1;
        cycle(15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
